// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: captures decoded controls and operands from ID for the EXE stage,
// with hazard freeze, branch flush and bubble insertion for invalid ID slots.
module id_exe_pipe_reg #(
    parameter int REGISTER_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic [REGISTER_LEN-1:0] pc_in,
    input  logic [REGISTER_LEN-1:0] val_rn_in,
    input  logic [REGISTER_LEN-1:0] val_rm_in,
    input  logic [11:0]             shift_operand_in,
    input  logic                    immd_in,
    input  logic [23:0]             signed_imm24_in,
    input  logic [3:0]              dest_in,
    input  logic [3:0]              src1_in,
    input  logic [3:0]              src2_in,
    input  logic [3:0]              exe_cmd_in,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic [3:0]              status_in,
    output logic                    valid_out,
    output logic [REGISTER_LEN-1:0] pc_out,
    output logic [REGISTER_LEN-1:0] val_rn_out,
    output logic [REGISTER_LEN-1:0] val_rm_out,
    output logic [11:0]             shift_operand_out,
    output logic                    immd_out,
    output logic [23:0]             signed_imm24_out,
    output logic [3:0]              dest_out,
    output logic [3:0]              src1_out,
    output logic [3:0]              src2_out,
    output logic [3:0]              exe_cmd_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic [3:0]              status_out,
    output logic                    is_mem_command
);

    typedef struct packed {
        logic                    valid;
        logic [REGISTER_LEN-1:0] pc;
        logic [REGISTER_LEN-1:0] val_rn;
        logic [REGISTER_LEN-1:0] val_rm;
        logic [11:0]             shift_operand;
        logic                    immd;
        logic [23:0]             signed_imm24;
        logic [3:0]              dest;
        logic [3:0]              src1;
        logic [3:0]              src2;
        logic [3:0]              exe_cmd;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    b;
        logic                    s;
        logic [3:0]              status;
        logic                    is_mem;
    } stage_t;

    stage_t stage_q;
    stage_t load_d;

    // Data fields always follow ID; controls are qualified by valid_in so an empty slot is a bubble.
    always_comb begin
        load_d               = '0;
        load_d.valid         = valid_in;
        load_d.pc            = pc_in;
        load_d.val_rn        = val_rn_in;
        load_d.val_rm        = val_rm_in;
        load_d.shift_operand = shift_operand_in;
        load_d.immd          = immd_in;
        load_d.signed_imm24  = signed_imm24_in;
        load_d.dest          = dest_in;
        load_d.src1          = src1_in;
        load_d.src2          = src2_in;
        load_d.exe_cmd       = exe_cmd_in;
        load_d.status        = status_in;
        load_d.wb_en         = valid_in & wb_en_in;
        load_d.mem_r_en      = valid_in & mem_r_en_in;
        load_d.mem_w_en      = valid_in & mem_w_en_in;
        load_d.b             = valid_in & b_in;
        load_d.s             = valid_in & s_in;
        load_d.is_mem        = valid_in & (mem_r_en_in | mem_w_en_in);
    end

    // Flush beats freeze: a taken branch kills the ID instruction even while stalled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every field updates from pre-edge values, like real flops.
        if (rst) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (!freeze) begin
            stage_q <= load_d;
        end
    end

    assign valid_out         = stage_q.valid;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign shift_operand_out = stage_q.shift_operand;
    assign immd_out          = stage_q.immd;
    assign signed_imm24_out  = stage_q.signed_imm24;
    assign dest_out          = stage_q.dest;
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign wb_en_out         = stage_q.wb_en;
    assign mem_r_en_out      = stage_q.mem_r_en;
    assign mem_w_en_out      = stage_q.mem_w_en;
    assign b_out             = stage_q.b;
    assign s_out             = stage_q.s;
    assign status_out        = stage_q.status;
    assign is_mem_command    = stage_q.is_mem;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed self-checking bench for id_exe_pipe_reg: reset, load, freeze, flush, bubble and
// reset-during-stall scenarios with hand-computed expectations.
module tb_id_exe_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic        immd_in;
    logic [23:0] signed_imm24_in;
    logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  status_in;

    logic        valid_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic        immd_out;
    logic [23:0] signed_imm24_out;
    logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic [3:0]  status_out;
    logic        is_mem_command;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.REGISTER_LEN(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .immd_in(immd_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .exe_cmd_in(exe_cmd_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
        .status_in(status_in),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
        .immd_out(immd_out), .signed_imm24_out(signed_imm24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .status_out(status_out),
        .is_mem_command(is_mem_command)
    );

    // Every output flattened, so whole-stage expectations are one comparison.
    logic [159:0] all_out;
    assign all_out = {valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, immd_out,
                      signed_imm24_out, dest_out, src1_out, src2_out, exe_cmd_out,
                      wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, status_out,
                      is_mem_command};

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 0; pc_in = '0; val_rn_in = '0; val_rm_in = '0; shift_operand_in = '0;
        immd_in = 0; signed_imm24_in = '0; dest_in = '0; src1_in = '0; src2_in = '0;
        exe_cmd_in = '0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
        status_in = '0;
    endtask

    initial begin
        // Reset with every input nonzero.
        rst = 1; freeze = 1; flush = 0;
        valid_in = 1; pc_in = 32'hDEAD_BEEF; val_rn_in = 32'h1234_5678; val_rm_in = 32'h9ABC_DEF0;
        shift_operand_in = 12'hFFF; immd_in = 1; signed_imm24_in = 24'hABCDEF; dest_in = 4'hF;
        src1_in = 4'hE; src2_in = 4'hD; exe_cmd_in = 4'hC; wb_en_in = 1; mem_r_en_in = 1;
        mem_w_en_in = 1; b_in = 1; s_in = 1; status_in = 4'hF;
        tick();
        check("reset_cycle1_all", all_out, '0);
        freeze = 0;
        tick();
        check("reset_cycle2_all", all_out, '0);
        check("reset_valid", {159'd0, valid_out}, '0);

        // Plain load of a valid instruction.
        rst = 0; clear_inputs();
        pc_in = 32'h10; val_rm_in = 32'hF0; shift_operand_in = 12'h1E3; immd_in = 1;
        wb_en_in = 1; valid_in = 1;
        tick();
        check("load_all", all_out,
              {1'b1, 32'h10, 32'h0, 32'hF0, 12'h1E3, 1'b1, 24'h0, 4'h0, 4'h0, 4'h0, 4'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
        check("load_is_mem", {159'd0, is_mem_command}, '0);

        // Three-cycle freeze; status and pc inputs change but must not be taken.
        freeze = 1; pc_in = 32'h20; status_in = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("freeze%0d_pc", i), {128'd0, pc_out}, {128'd0, 32'h10});
            check($sformatf("freeze%0d_valid_status", i), {155'd0, valid_out, status_out},
                  {155'd0, 1'b1, 4'h0});
        end
        freeze = 0;
        tick();
        check("unfreeze_pc", {128'd0, pc_out}, {128'd0, 32'h20});
        check("unfreeze_status", {156'd0, status_out}, {156'd0, 4'h5});

        // Flush together with freeze wins and yields a bubble.
        freeze = 1; flush = 1; valid_in = 1; mem_w_en_in = 1;
        tick();
        check("flush_over_freeze_all", all_out, '0);

        // Invalid slot: controls forced low even though inputs request them.
        freeze = 0; flush = 0; clear_inputs();
        mem_r_en_in = 1; wb_en_in = 1; b_in = 1; s_in = 1; valid_in = 0; pc_in = 32'h30;
        tick();
        check("bubble_controls",
              {154'd0, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
               is_mem_command}, '0);
        b_in = 0; s_in = 0; valid_in = 1;
        tick();
        check("valid_load_controls",
              {155'd0, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, is_mem_command},
              {155'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});

        // Store, then reset arriving during a freeze clears the stage.
        clear_inputs();
        mem_w_en_in = 1; valid_in = 1; pc_in = 32'h40; dest_in = 4'h3; exe_cmd_in = 4'h2;
        tick();
        check("store_load",
              {120'd0, pc_out, dest_out, exe_cmd_out, mem_w_en_out, mem_r_en_out, is_mem_command},
              {120'd0, 32'h40, 4'h3, 4'h2, 1'b1, 1'b0, 1'b1});
        freeze = 1; rst = 1;
        tick();
        check("reset_during_freeze_all", all_out, '0);
        rst = 0; freeze = 0; clear_inputs();
        pc_in = 32'h50; valid_in = 1; wb_en_in = 1; val_rn_in = 32'hCAFE; src1_in = 4'h7;
        tick();
        check("post_reset_load", all_out,
              {1'b1, 32'h50, 32'hCAFE, 32'h0, 12'h0, 1'b0, 24'h0, 4'h0, 4'h7, 4'h0, 4'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});

        // Flush alone, without freeze.
        flush = 1;
        tick();
        check("flush_alone_all", all_out, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
